booth_mul_arbiter: RTL and testbench

- Shares one 4x4 signed radix-4 Booth multiplier (registered, fixed latency) between two requesters.
- Each requester has an independent valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration, at most one issue per cycle, fully pipelined.
- Results are tagged through the multiplier latency and steered into per-requester response FIFOs. Credit checks guarantee these FIFOs never overflow.

---
 rtl/booth_mul_pkg.sv | 23 ++
 rtl/booth_rsp_fifo.sv | 78 +++++++
 rtl/booth_mul_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_booth_mul_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mul_pkg.sv
// Shared definitions for the Booth multiplier arbiter.
//
// Contents:
//   NREQ    number of requesters that share the multiplier
//   OP_W    operand width (signed)
//   PROD_W  product width (signed, full 4x4 range)
//   ID_W    width of a requester id
//   tag_t   {valid, id} carried alongside each op through the multiplier latency
package booth_mul_pkg;

  localparam int NREQ   = 2;
  localparam int OP_W   = 4;
  localparam int PROD_W = 8;
  localparam int ID_W   = 1;

  // One entry of the tag pipe. The id selects the response FIFO that
  // receives mul_result when this entry reaches the last stage.
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/booth_rsp_fifo.sv
// Per-requester response FIFO.
//
// A small circular buffer holding multiplier results until the consumer
// pops them. Push and pop on the same edge leave the occupancy unchanged.
// A pop on an empty FIFO is ignored. The head reads as zero when empty, so
// rsp_data is quiet whenever rsp_valid is low.
//
// Parameters:
//   DEPTH  entries, power of two (2..8)
//   WIDTH  data width
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset (FIFO emptied)
//   push       write push_data at the tail
//   push_data  data to write
//   pop        consumer takes the head entry
//   head       head entry, zero when empty
//   count      current occupancy (0..DEPTH)
//   empty      occupancy is zero
//   full       occupancy is DEPTH
module booth_rsp_fifo #(
  parameter int  DEPTH = 2,
  parameter int  WIDTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A push into a full FIFO is dropped unless a pop frees the slot on the
  // same edge; upstream credit accounting keeps that case from arising.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset: an entry is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one external registered 4x4 signed Booth multiplier between two
// requesters.
//
// Each cycle at most one request is issued to the multiplier. Arbitration is
// round-robin between eligible requesters; a requester is eligible only when
// its response FIFO has room for everything already in flight plus one more
// (credit check), so results never overflow a FIFO and a stalled consumer
// only blocks its own requester.
//
// Handshakes: every channel is valid/ready. A transfer happens on the rising
// edge where valid and ready are both high; ready never depends on the
// transfer of the same edge in the other direction, and req_ready is never
// high without the matching req_valid.
//
// Parameters:
//   MUL_LAT     issue edge to valid mul_result, in cycles (1..4)
//   FIFO_DEPTH  entries per response FIFO, power of two (2..8)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   req_valid   request valid, bit i = requester i
//   req_ready   request accepted (grant), bit i
//   req_x       multiplicands, requester i at [4i+3:4i]
//   req_m       multipliers,   requester i at [4i+3:4i]
//   rsp_valid   response FIFO i non-empty
//   rsp_ready   consumer i pops its head entry
//   rsp_data    products, requester i at [8i+7:8i], zero when empty
//   mul_x       multiplicand to the shared multiplier
//   mul_m       multiplier operand to the shared multiplier
//   mul_result  product from the shared multiplier
//   busy        any op in flight or any FIFO non-empty
module booth_mul_arbiter
  import booth_mul_pkg::*;
#(
  parameter int MUL_LAT    = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*OP_W-1:0]   req_x,
  input  logic [NREQ*OP_W-1:0]   req_m,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [NREQ*PROD_W-1:0] rsp_data,
  output logic [OP_W-1:0]        mul_x,
  output logic [OP_W-1:0]        mul_m,
  input  logic [PROD_W-1:0]      mul_result,
  output logic                   busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  // Arbitration
  logic [NREQ-1:0] eligible;
  logic            grant;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] rr;

  // Issue path
  logic [OP_W-1:0] sel_x;
  logic [OP_W-1:0] sel_m;
  logic [OP_W-1:0] held_x;
  logic [OP_W-1:0] held_m;

  // Tag pipe
  tag_t tag_pipe [MUL_LAT];
  tag_t tag_last;

  // Credit and FIFO bookkeeping
  logic [NREQ-1:0]  infl_inc;
  logic [CNT_W-1:0] inflight   [NREQ];
  logic [CNT_W-1:0] fifo_count [NREQ];
  logic [NREQ-1:0]  fifo_push;
  logic [NREQ-1:0]  fifo_pop;
  logic [NREQ-1:0]  fifo_empty;
  logic [NREQ-1:0]  fifo_full;

  // --------------------------------------------------------------------
  // Credit check: occupancy plus in-flight ops must stay below the depth
  // for one more op to be accepted. The full flag is implied by the sum
  // but keeps the mask readable when probing.
  // --------------------------------------------------------------------
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid[i] && !fifo_full[i] &&
                    ((SUM_W'(fifo_count[i]) + SUM_W'(inflight[i])) < SUM_W'(FIFO_DEPTH));
    end
  end

  // --------------------------------------------------------------------
  // Round-robin grant. Gated by rst so nothing is offered while the tag
  // pipe and FIFOs are being cleared.
  // --------------------------------------------------------------------
  always_comb begin
    grant     = 1'b0;
    gnt_id    = '0;
    req_ready = '0;
    if (!rst) begin
      if (&eligible) begin
        grant  = 1'b1;
        gnt_id = rr;
      end else if (eligible[0]) begin
        grant  = 1'b1;
        gnt_id = ID_W'(0);
      end else if (eligible[1]) begin
        grant  = 1'b1;
        gnt_id = ID_W'(1);
      end
    end
    if (grant) req_ready[gnt_id] = 1'b1;
  end

  // Operands of the granted requester go straight to the multiplier in the
  // issue cycle; otherwise the last issued pair is held so the multiplier
  // inputs do not toggle while idle.
  assign sel_x = req_x[OP_W*int'(gnt_id) +: OP_W];
  assign sel_m = req_m[OP_W*int'(gnt_id) +: OP_W];
  assign mul_x = grant ? sel_x : held_x;
  assign mul_m = grant ? sel_m : held_m;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr     <= '0;
      held_x <= '0;
      held_m <= '0;
    end else if (grant) begin
      rr     <= ~gnt_id;
      held_x <= sel_x;
      held_m <= sel_m;
    end
  end

  // --------------------------------------------------------------------
  // Tag pipe: mirrors the multiplier latency so the result arriving on
  // mul_result can be steered to the FIFO of the requester that issued it.
  // Clearing it on reset is what makes stale multiplier outputs harmless.
  // --------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MUL_LAT; k++) tag_pipe[k] <= '0;
    end else begin
      tag_pipe[0] <= '{valid: grant, id: gnt_id};
      for (int k = 1; k < MUL_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  assign tag_last = tag_pipe[MUL_LAT-1];

  always_comb begin
    infl_inc  = '0;
    fifo_push = '0;
    fifo_pop  = '0;
    for (int i = 0; i < NREQ; i++) begin
      infl_inc[i]  = grant && (gnt_id == ID_W'(i));
      fifo_push[i] = tag_last.valid && (tag_last.id == ID_W'(i));
      fifo_pop[i]  = rsp_ready[i] && !fifo_empty[i];
    end
  end

  // In-flight counters: up on a grant, down when the result lands in the
  // FIFO. Both on one edge cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) inflight[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        case ({infl_inc[i], fifo_push[i]})
          2'b10:   inflight[i] <= inflight[i] + CNT_W'(1);
          2'b01:   inflight[i] <= inflight[i] - CNT_W'(1);
          default: inflight[i] <= inflight[i];
        endcase
      end
    end
  end

  // --------------------------------------------------------------------
  // Response FIFOs
  // --------------------------------------------------------------------
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_fifo
    booth_rsp_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PROD_W)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push[gi]),
      .push_data (mul_result),
      .pop       (fifo_pop[gi]),
      .head      (rsp_data[gi*PROD_W +: PROD_W]),
      .count     (fifo_count[gi]),
      .empty     (fifo_empty[gi]),
      .full      (fifo_full[gi])
    );
    assign rsp_valid[gi] = !fifo_empty[gi];
  end

  // Busy while any tag is live or any FIFO still holds a result.
  always_comb begin
    busy = ~&fifo_empty;
    for (int k = 0; k < MUL_LAT; k++) busy = busy | tag_pipe[k].valid;
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter with default parameters
// (MUL_LAT=1, FIFO_DEPTH=2). The shared multiplier is modelled here as a
// MUL_LAT-stage register pipeline; expected products are hand-computed
// constants attached to each request.
module tb_booth_mul_arbiter;

  localparam int MUL_LAT    = 1;
  localparam int FIFO_DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [7:0]  req_x = '0;
  logic [7:0]  req_m = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = '0;
  logic [15:0] rsp_data;
  logic [3:0]  mul_x;
  logic [3:0]  mul_m;
  logic [7:0]  mul_result;
  logic        busy;

  always #5 clk = ~clk;

  booth_mul_arbiter #(.MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_m      (req_m),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .mul_x      (mul_x),
    .mul_m      (mul_m),
    .mul_result (mul_result),
    .busy       (busy)
  );

  // ---------------- external multiplier model ----------------
  logic signed [7:0] sx;
  logic signed [7:0] sm;
  logic [7:0]        mp [MUL_LAT];
  assign sx = {{4{mul_x[3]}}, mul_x};
  assign sm = {{4{mul_m[3]}}, mul_m};
  always @(posedge clk) begin
    mp[0] <= sx * sm;
    for (int k = 1; k < MUL_LAT; k++) mp[k] <= mp[k-1];
  end
  assign mul_result = mp[MUL_LAT-1];

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int   gnt_log[$];
  int   acc_cyc[$];
  int   acc_cnt [2];
  int   rsp_cnt [2];
  int   cyc = 0;
  logic [7:0] pend0;
  logic [7:0] pend1;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are sampled at the falling edge, ahead of the rising edge
  // on which they complete.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          if (i == 0) exp_q0.push_back(pend0);
          else        exp_q1.push_back(pend1);
          acc_cnt[i]++;
          gnt_log.push_back(i);
          acc_cyc.push_back(cyc);
        end
        if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_cnt[i]++;
          if (i == 0) begin
            if (exp_q0.size() == 0) check_eq("rsp0_unexpected", 16'(rsp_valid[0]), 16'h0);
            else                    check_eq("rsp0_data", 16'(rsp_data[7:0]), 16'(exp_q0.pop_front()));
          end else begin
            if (exp_q1.size() == 0) check_eq("rsp1_unexpected", 16'(rsp_valid[1]), 16'h0);
            else                    check_eq("rsp1_data", 16'(rsp_data[15:8]), 16'(exp_q1.pop_front()));
          end
        end
        if (u_dut.fifo_push[i]) check_eq("fifo_no_overflow", 16'(u_dut.fifo_full[i]), 16'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  logic [15:0] tbl0 [8];
  logic [15:0] tbl1 [8];
  int n0, n1, idx0, idx1;

  task automatic clear_sb();
    exp_q0.delete();
    exp_q1.delete();
    gnt_log.delete();
    acc_cyc.delete();
    acc_cnt[0] = 0; acc_cnt[1] = 0;
    rsp_cnt[0] = 0; rsp_cnt[1] = 0;
  endtask

  // Ends at a rising edge + 1.
  task automatic do_reset();
    req_valid = '0;
    rst = 1'b1;
    clear_sb();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic issue_one(input int id, input logic [3:0] x, input logic [3:0] m, input logic [7:0] p);
    int c;
    if (id == 0) begin req_x[3:0] = x; req_m[3:0] = m; pend0 = p; end
    else         begin req_x[7:4] = x; req_m[7:4] = m; pend1 = p; end
    req_valid[id] = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!req_ready[id] && c < 20);
    check_eq("issue_accept", 16'(req_ready[id]), 16'h1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic drive_stream();
    req_valid[0] = (idx0 < n0);
    req_valid[1] = (idx1 < n1);
    if (idx0 < n0) begin req_x[3:0] = tbl0[idx0][15:12]; req_m[3:0] = tbl0[idx0][11:8]; pend0 = tbl0[idx0][7:0]; end
    if (idx1 < n1) begin req_x[7:4] = tbl1[idx1][15:12]; req_m[7:4] = tbl1[idx1][11:8]; pend1 = tbl1[idx1][7:0]; end
  endtask

  task automatic stream_start(input int a, input int b);
    n0 = a; n1 = b; idx0 = 0; idx1 = 0;
    drive_stream();
  endtask

  task automatic stream_run(input int cycles);
    logic [1:0] acc;
    for (int c = 0; c < cycles && (idx0 < n0 || idx1 < n1); c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      if (acc[0]) idx0++;
      if (acc[1]) idx1++;
      drive_stream();
    end
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while ((busy || exp_q0.size() != 0 || exp_q1.size() != 0) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check_eq("drain_idle", 16'(busy), 16'h0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    int c;
    logic [7:0] bp_exp;
    clear_sb();

    // Reset state, with requests pending to prove ready is gated.
    req_valid = 2'b11; req_x = 8'h35; req_m = 8'h27;
    #1 rst = 1'b1;
    #2;
    check_eq("rst_req_ready", 16'(req_ready), 16'h0);
    check_eq("rst_rsp_valid", 16'(rsp_valid), 16'h0);
    check_eq("rst_rsp_data",  rsp_data, 16'h0);
    check_eq("rst_mul_x",     16'(mul_x), 16'h0);
    check_eq("rst_mul_m",     16'(mul_m), 16'h0);
    check_eq("rst_busy",      16'(busy), 16'h0);
    do_reset();

    // Single op: 3 * -2 = -6.
    rsp_ready = 2'b11;
    req_x[3:0] = 4'h3; req_m[3:0] = 4'hE; pend0 = 8'hFA;
    req_valid = 2'b01;
    @(negedge clk);
    check_eq("single_ready", 16'(req_ready), 16'h1);
    check_eq("single_mul_x", 16'(mul_x), 16'h3);
    check_eq("single_mul_m", 16'(mul_m), 16'hE);
    @(posedge clk); #1;
    req_valid = 2'b00;
    check_eq("single_busy", 16'(busy), 16'h1);
    check_eq("hold_mul_x", 16'(mul_x), 16'h3);
    lat = 1;
    while (!rsp_valid[0] && lat < 10) begin @(posedge clk); #1; lat++; end
    check_eq("single_latency", 16'(lat), 16'(MUL_LAT + 1));
    check_eq("single_data", 16'(rsp_data[7:0]), 16'h00FA);
    wait_idle(20);
    check_eq("single_no_rsp1", 16'(rsp_cnt[1]), 16'h0);

    // Corner values.
    issue_one(0, 4'h8, 4'h8, 8'h40);
    issue_one(1, 4'h7, 4'h8, 8'hC8);
    issue_one(0, 4'h0, 4'h5, 8'h00);
    wait_idle(20);
    check_eq("idle_hold_mul_x", 16'(mul_x), 16'h0);
    check_eq("idle_hold_mul_m", 16'(mul_m), 16'h5);

    // Contention: alternate grants starting with requester 0 after reset.
    do_reset();
    rsp_ready = 2'b11;
    tbl0[0] = 16'h1101; tbl0[1] = 16'hFF01; tbl0[2] = 16'h2DFA; tbl0[3] = 16'hC4F0;
    tbl1[0] = 16'h3309; tbl1[1] = 16'hE5F6; tbl1[2] = 16'h7731; tbl1[3] = 16'h87C8;
    stream_start(4, 4);
    stream_run(40);
    check_eq("cont_done0", 16'(idx0), 16'h4);
    check_eq("cont_done1", 16'(idx1), 16'h4);
    wait_idle(20);
    check_eq("cont_grants", 16'(gnt_log.size()), 16'h8);
    for (int k = 0; k < gnt_log.size(); k++) check_eq("cont_order", 16'(gnt_log[k]), 16'(k % 2));
    if (acc_cyc.size() > 0) check_eq("cont_span", 16'(acc_cyc[acc_cyc.size()-1] - acc_cyc[0]), 16'h7);

    // Back-pressure on requester 0.
    clear_sb();
    rsp_ready = 2'b10;
    tbl0[0] = 16'h6FFA; tbl0[1] = 16'hBB19; tbl0[2] = 16'h430C; tbl0[3] = 16'hD915;
    tbl1[0] = 16'h18F8; tbl1[1] = 16'h2204; tbl1[2] = 16'hA3EE;
    tbl1[3] = 16'h5519; tbl1[4] = 16'hF7F9; tbl1[5] = 16'h3CF4;
    stream_start(4, 6);
    stream_run(10);
    check_eq("bp_acc0", 16'(acc_cnt[0]), 16'(FIFO_DEPTH));
    check_eq("bp_acc1", 16'(acc_cnt[1]), 16'h6);
    check_eq("bp_masked", 16'(req_ready[0]), 16'h0);
    check_eq("bp_grants", 16'(gnt_log.size()), 16'h8);
    bp_exp = 8'b1111_1010;
    for (int k = 0; k < gnt_log.size() && k < 8; k++) check_eq("bp_order", 16'(gnt_log[k]), 16'(bp_exp[k]));
    rsp_ready = 2'b11;
    stream_run(30);
    check_eq("bp_done0", 16'(idx0), 16'h4);
    wait_idle(30);
    check_eq("bp_drained", 16'(rsp_cnt[0]), 16'h4);

    // Push and pop on the same edge.
    clear_sb();
    rsp_ready = 2'b10;
    issue_one(0, 4'h5, 4'hD, 8'hF1);
    c = 0;
    while (!rsp_valid[0] && c < 10) begin @(posedge clk); #1; c++; end
    check_eq("pp_first", 16'(rsp_valid[0]), 16'h1);
    issue_one(0, 4'h9, 4'h6, 8'hD6);
    rsp_ready = 2'b11;
    @(posedge clk); #1;
    check_eq("pp_hold", 16'(rsp_valid[0]), 16'h1);
    check_eq("pp_data", 16'(rsp_data[7:0]), 16'h00D6);
    @(posedge clk); #1;
    check_eq("pp_drain", 16'(rsp_valid[0]), 16'h0);

    // Asynchronous reset with an op in flight.
    issue_one(0, 4'h3, 4'h3, 8'h09);
    #1;
    req_valid = 2'b11;
    rst = 1'b1;
    clear_sb();
    #1;
    check_eq("arst_req_ready", 16'(req_ready), 16'h0);
    check_eq("arst_rsp_valid", 16'(rsp_valid), 16'h0);
    check_eq("arst_rsp_data",  rsp_data, 16'h0);
    check_eq("arst_mul_x",     16'(mul_x), 16'h0);
    check_eq("arst_mul_m",     16'(mul_m), 16'h0);
    check_eq("arst_busy",      16'(busy), 16'h0);
    req_valid = 2'b00;
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_eq("arst_no_stale", 16'(rsp_valid), 16'h0);
    end
    tbl0[0] = 16'h2306;
    tbl1[0] = 16'hEE04;
    stream_start(1, 1);
    stream_run(10);
    wait_idle(20);
    check_eq("arst_rr_first", 16'(gnt_log.size() > 0 ? gnt_log[0] : 9), 16'h0);

    check_eq("end_q0_empty", 16'(exp_q0.size()), 16'h0);
    check_eq("end_q1_empty", 16'(exp_q1.size()), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
